// File: rtl/block_accum_fifo.sv
// Block accumulator: sums N_BLOCK valid samples, saturates to s16,
// and queues results in a first-word-fall-through FIFO.
module block_accum_fifo #(
  parameter int N_BLOCK    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [15:0]            in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [15:0]            out_data,
  output logic                          out_sat,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow
);

  localparam int CW = $clog2(N_BLOCK);
  localparam int AW = 16 + CW;
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic signed [AW-1:0] MAXV = AW'(32767);
  localparam logic signed [AW-1:0] MINV = AW'(-32768);
  localparam logic [CW-1:0]        LAST = CW'(N_BLOCK - 1);
  localparam logic [PW:0]          DEPTH = (PW + 1)'(FIFO_DEPTH);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic [CW-1:0]        cnt;
  logic                 last;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 sat;
  logic signed [15:0]   sat_d;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [16:0]          mem [FIFO_DEPTH];

  assign last = in_valid && (cnt == LAST);
  assign sum  = acc + AW'(in_data);
  assign full = (fill_level == DEPTH);
  assign pop  = out_valid && out_ready;
  // A full FIFO still accepts a result if its head leaves on the same edge.
  assign push = last && (!full || pop);

  always_comb begin
    sat   = 1'b0;
    sat_d = sum[15:0];
    if (sum > MAXV) begin
      sat   = 1'b1;
      sat_d = 16'sh7fff;
    end else if (sum < MINV) begin
      sat   = 1'b1;
      sat_d = 16'sh8000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fill_level <= fill_level + 1'b1;
      else if (pop && !push) fill_level <= fill_level - 1'b1;
      if (last && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sat, sat_d};
  end

  assign out_valid = (fill_level != '0);
  assign out_data  = out_valid ? mem[rd_ptr][15:0] : '0;
  assign out_sat   = out_valid ? mem[rd_ptr][16] : 1'b0;

endmodule

// File: tb/tb_block_accum_fifo.sv
// Bench for block_accum_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_block_accum_fifo;

  localparam int NB = 4;
  localparam int DEPTH = 4;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic [2:0]         fill_level;
  logic               overflow;

  int checks = 0;
  int failures = 0;

  block_accum_fifo #(.N_BLOCK(NB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat),
    .fill_level(fill_level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integers and a queue of {sat, data}.
  int m_acc = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  logic [16:0] q[$];

  always @(posedge clk or negedge rst) begin
    int s;
    bit p_pop;
    bit p_full;
    bit p_push;
    logic [16:0] r;
    if (!rst) begin
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
      q.delete();
    end else begin
      p_pop  = (q.size() != 0) && out_ready;
      p_full = (q.size() == DEPTH);
      p_push = 1'b0;
      r = '0;
      if (in_valid) begin
        s = m_acc + int'(in_data);
        if (m_cnt == NB - 1) begin
          p_push = 1'b1;
          if (s > 32767)       r = {1'b1, 16'h7fff};
          else if (s < -32768) r = {1'b1, 16'h8000};
          else                 r = {1'b0, 16'(s)};
          m_acc = 0;
          m_cnt = 0;
        end else begin
          m_acc = s;
          m_cnt = m_cnt + 1;
        end
      end
      if (p_pop) void'(q.pop_front());
      if (p_push) begin
        if (p_full && !p_pop) m_ovf = 1'b1;
        else q.push_back(r);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int ev;
    int ed;
    int es;
    ev = (q.size() != 0) ? 1 : 0;
    ed = ev ? int'($signed(q[0][15:0])) : 0;
    es = ev ? int'(q[0][16]) : 0;
    chk("cmp_valid", int'(out_valid), ev);
    chk("cmp_data", int'(out_data), ed);
    chk("cmp_sat", int'(out_sat), es);
    chk("cmp_fill", int'(fill_level), q.size());
    chk("cmp_ovf", int'(overflow), int'(m_ovf));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input int d);
    in_valid = 1'b1;
    in_data  = 16'(d);
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic zero_outs(input string nm);
    chk({nm, "_valid"}, int'(out_valid), 0);
    chk({nm, "_data"}, int'(out_data), 0);
    chk({nm, "_sat"}, int'(out_sat), 0);
    chk({nm, "_fill"}, int'(fill_level), 0);
    chk({nm, "_ovf"}, int'(overflow), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #1 rst = 1'b0;
    #1 zero_outs("reset");
    step();
    rst = 1'b1;
    step();

    // basic block sum
    out_ready = 1'b1;
    samp(1); samp(2); samp(3); samp(4);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 10);
    chk("t1_sat", int'(out_sat), 0);
    step();
    chk("t1_valid_low", int'(out_valid), 0);
    chk("t1_fill", int'(fill_level), 0);

    // saturation both ways, then in-range
    repeat (4) samp(20000);
    chk("t2_pos_data", int'(out_data), 32767);
    chk("t2_pos_sat", int'(out_sat), 1);
    repeat (4) samp(-20000);
    chk("t2_neg_data", int'(out_data), -32768);
    chk("t2_neg_sat", int'(out_sat), 1);
    repeat (4) samp(8000);
    chk("t2_mid_data", int'(out_data), 32000);
    chk("t2_mid_sat", int'(out_sat), 0);
    step();

    // idle gaps between valid samples
    samp(5); step(); step();
    samp(-3);
    samp(7); step(); step(); step();
    chk("t3_no_early", int'(out_valid), 0);
    samp(1);
    chk("t3_data", int'(out_data), 10);
    step();

    // backpressure and overflow
    out_ready = 1'b0;
    repeat (20) samp(1);
    chk("t4_fill", int'(fill_level), 4);
    chk("t4_ovf", int'(overflow), 1);
    chk("t4_data", int'(out_data), 4);
    step();
    chk("t4_hold", int'(out_data), 4);
    out_ready = 1'b1;
    step(); step(); step();
    chk("t4_fill_one", int'(fill_level), 1);
    chk("t4_last_data", int'(out_data), 4);
    step();
    chk("t4_drained", int'(out_valid), 0);
    chk("t4_ovf_sticky", int'(overflow), 1);
    out_ready = 1'b0;

    // full FIFO with simultaneous pop
    rst = 1'b0;
    #2 rst = 1'b1;
    step();
    chk("t5_ovf_clear", int'(overflow), 0);
    for (int b = 1; b <= 4; b++) repeat (4) samp(b);
    chk("t5_full", int'(fill_level), 4);
    samp(5); samp(5); samp(5);
    out_ready = 1'b1;
    samp(5);
    chk("t5_ovf", int'(overflow), 0);
    chk("t5_fill", int'(fill_level), 4);
    chk("t5_head", int'(out_data), 8);
    step(); step(); step();
    chk("t5_tail", int'(out_data), 20);
    chk("t5_tail_fill", int'(fill_level), 1);
    step();
    chk("t5_empty", int'(out_valid), 0);
    out_ready = 1'b0;

    // reset mid-operation
    repeat (4) samp(1);
    samp(9); samp(9);
    chk("t6_queued", int'(fill_level), 1);
    #3 rst = 1'b0;
    #1 zero_outs("t6_rst");
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) samp(1);
    chk("t6_valid", int'(out_valid), 1);
    chk("t6_data", int'(out_data), 4);
    step();
    chk("t6_empty", int'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
